// File: rtl/multi_digit_printer_pkg.sv
// Shared definitions for the multi-digit glyph printer: FSM encoding, blank glyph
// code, default geometry and the screen-coordinate helper.
package multi_digit_printer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD     = 3'd1,
        ST_EMIT     = 3'd2,
        ST_WAIT_ACK = 3'd3,
        ST_FINISH   = 3'd4
    } state_t;

    localparam logic [3:0] BLANK_CODE = 4'd12;

    localparam int DEF_NUM_FIELDS = 2;
    localparam int DEF_NUM_DIGITS = 4;
    localparam int DEF_DIGIT_BITS = 1;
    localparam int DEF_BASE_X     = 151;
    localparam int DEF_BASE_Y     = 87;
    localparam int DEF_PITCH_X    = 9;
    localparam int DEF_PITCH_Y    = 16;

    // Screen coordinates are 10 bits and intentionally wrap modulo 1024.
    function automatic logic [9:0] coord(input int base, input int idx, input int pitch);
        return 10'(base + idx * pitch);
    endfunction

endpackage

// File: rtl/multi_digit_printer_digit_select.sv
// Combinational digit extraction (digit 0 = most significant) plus a flag that is
// set when the selected digit and every more significant digit are zero.
module digit_select #(
    parameter int NUM_DIGITS = 4,
    parameter int DIGIT_BITS = 1
) (
    input  logic [NUM_DIGITS*DIGIT_BITS-1:0]                 field_i,
    input  logic [((NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1)-1:0] digit_idx_i,
    output logic [3:0]                                       digit_o,
    output logic                                             lead_zero_o
);

    // Walk digits from the most significant end down to the selected one.
    always_comb begin
        digit_o     = 4'd0;
        lead_zero_o = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (i <= int'(digit_idx_i)) begin
                if (field_i[(NUM_DIGITS-1-i)*DIGIT_BITS +: DIGIT_BITS] != '0) begin
                    lead_zero_o = 1'b0;
                end else begin
                    lead_zero_o = lead_zero_o;
                end
            end else begin
                lead_zero_o = lead_zero_o;
            end
            if (i == int'(digit_idx_i)) begin
                digit_o = 4'(field_i[(NUM_DIGITS-1-i)*DIGIT_BITS +: DIGIT_BITS]);
            end else begin
                digit_o = digit_o;
            end
        end
    end

endmodule

// File: rtl/multi_digit_printer.sv
// Prints NUM_FIELDS rows of NUM_DIGITS digits to a glyph renderer, one digit per
// VALID/READY handshake, from a snapshot of DATA taken when a pass starts.
module multi_digit_printer
    import multi_digit_printer_pkg::*;
#(
    parameter int NUM_FIELDS = DEF_NUM_FIELDS,
    parameter int NUM_DIGITS = DEF_NUM_DIGITS,
    parameter int DIGIT_BITS = DEF_DIGIT_BITS,
    parameter int BASE_X     = DEF_BASE_X,
    parameter int BASE_Y     = DEF_BASE_Y,
    parameter int PITCH_X    = DEF_PITCH_X,
    parameter int PITCH_Y    = DEF_PITCH_Y
) (
    input  logic                                   F25MHZ,
    input  logic                                   RST_N,
    input  logic                                   START,
    input  logic                                   LZ_SUPPRESS,
    input  logic [NUM_FIELDS*NUM_DIGITS*DIGIT_BITS-1:0] DATA,
    input  logic                                   READY,
    output logic [9:0]                             DIGIT_LOW_X,
    output logic [9:0]                             DIGIT_LOW_Y,
    output logic [3:0]                             NUMBER,
    output logic                                   VALID,
    output logic                                   BUSY,
    output logic                                   DONE
);

    localparam int FW  = NUM_DIGITS * DIGIT_BITS;
    localparam int DW  = NUM_FIELDS * FW;
    localparam int FCW = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1;
    localparam int DCW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    state_t          state_q, state_d;
    logic [DW-1:0]   snap_q, snap_d;
    logic [FCW-1:0]  field_q, field_d;
    logic [DCW-1:0]  digit_q, digit_d;
    logic [9:0]      x_q, x_d, y_q, y_d;
    logic [3:0]      num_q, num_d;
    logic            valid_q, valid_d, busy_q, busy_d, done_q, done_d;

    logic [FW-1:0]   field_val_s;
    logic [3:0]      digit_s;
    logic            lead_zero_s, last_digit_s, last_field_s;

    assign field_val_s  = snap_q[field_q*FW +: FW];
    assign last_digit_s = (int'(digit_q) == NUM_DIGITS - 1);
    assign last_field_s = (int'(field_q) == NUM_FIELDS - 1);

    digit_select #(
        .NUM_DIGITS (NUM_DIGITS),
        .DIGIT_BITS (DIGIT_BITS)
    ) u_digit_select (
        .field_i     (field_val_s),
        .digit_idx_i (digit_q),
        .digit_o     (digit_s),
        .lead_zero_o (lead_zero_s)
    );

    // Next-state and output-register decode; outputs change only on state exits.
    always_comb begin
        state_d = state_q;
        snap_d  = snap_q;
        field_d = field_q;
        digit_d = digit_q;
        x_d     = x_q;
        y_d     = y_q;
        num_d   = num_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    state_d = ST_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                snap_d  = DATA;
                field_d = '0;
                digit_d = '0;
                busy_d  = 1'b1;
                state_d = ST_EMIT;
            end
            ST_EMIT: begin
                x_d     = coord(BASE_X, int'(digit_q), PITCH_X);
                y_d     = coord(BASE_Y, int'(field_q), PITCH_Y);
                // The rightmost digit always prints so a zero field still shows "0".
                if (LZ_SUPPRESS && lead_zero_s && !last_digit_s) begin
                    num_d = BLANK_CODE;
                end else begin
                    num_d = digit_s;
                end
                valid_d = 1'b1;
                state_d = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                if (READY) begin
                    valid_d = 1'b0;
                    if (!last_digit_s) begin
                        digit_d = digit_q + 1'b1;
                        state_d = ST_EMIT;
                    end else if (!last_field_s) begin
                        digit_d = '0;
                        field_d = field_q + 1'b1;
                        state_d = ST_EMIT;
                    end else begin
                        state_d = ST_FINISH;
                    end
                end else begin
                    state_d = ST_WAIT_ACK;
                end
            end
            ST_FINISH: begin
                valid_d = 1'b0;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                num_d   = BLANK_CODE;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge F25MHZ or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
            snap_q  <= '0;
            field_q <= '0;
            digit_q <= '0;
            x_q     <= 10'(BASE_X);
            y_q     <= 10'(BASE_Y);
            num_q   <= BLANK_CODE;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            snap_q  <= snap_d;
            field_q <= field_d;
            digit_q <= digit_d;
            x_q     <= x_d;
            y_q     <= y_d;
            num_q   <= num_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign DIGIT_LOW_X = x_q;
    assign DIGIT_LOW_Y = y_q;
    assign NUMBER      = num_q;
    assign VALID       = valid_q;
    assign BUSY        = busy_q;
    assign DONE        = done_q;

endmodule

// File: tb/tb_multi_digit_printer.sv
// Bench for multi_digit_printer: three parameterisations driven by directed and
// randomized passes, checked against an arithmetic model of the printed digits.
module tb_multi_digit_printer;

    logic        clk = 1'b0;
    logic        rst_n, start, lz, ready;
    logic [63:0] data_s;
    int          sel;
    int          n_pass = 0;
    int          n_fail = 0;
    int          n_checks = 0;
    int          ex[$], ey[$], en[$];

    always #20 clk = ~clk;

    logic       st0, st1, st2;
    logic [9:0] x0, y0, x1, y1, x2, y2;
    logic [3:0] n0, n1, n2;
    logic       v0, v1, v2, b0, b1, b2, dn0, dn1, dn2;

    assign st0 = start & (sel == 0);
    assign st1 = start & (sel == 1);
    assign st2 = start & (sel == 2);

    multi_digit_printer u_dut0 (
        .F25MHZ(clk), .RST_N(rst_n), .START(st0), .LZ_SUPPRESS(lz), .DATA(data_s[7:0]),
        .READY(ready), .DIGIT_LOW_X(x0), .DIGIT_LOW_Y(y0), .NUMBER(n0), .VALID(v0),
        .BUSY(b0), .DONE(dn0));

    multi_digit_printer #(.NUM_FIELDS(1), .DIGIT_BITS(4)) u_dut1 (
        .F25MHZ(clk), .RST_N(rst_n), .START(st1), .LZ_SUPPRESS(lz), .DATA(data_s[15:0]),
        .READY(ready), .DIGIT_LOW_X(x1), .DIGIT_LOW_Y(y1), .NUMBER(n1), .VALID(v1),
        .BUSY(b1), .DONE(dn1));

    multi_digit_printer #(.BASE_X(1020)) u_dut2 (
        .F25MHZ(clk), .RST_N(rst_n), .START(st2), .LZ_SUPPRESS(lz), .DATA(data_s[7:0]),
        .READY(ready), .DIGIT_LOW_X(x2), .DIGIT_LOW_Y(y2), .NUMBER(n2), .VALID(v2),
        .BUSY(b2), .DONE(dn2));

    logic [9:0] ox, oy;
    logic [3:0] on;
    logic       ov, ob, od;

    always_comb begin
        if (sel == 0) begin
            ox = x0; oy = y0; on = n0; ov = v0; ob = b0; od = dn0;
        end else if (sel == 1) begin
            ox = x1; oy = y1; on = n1; ov = v1; ob = b1; od = dn1;
        end else begin
            ox = x2; oy = y2; on = n2; ov = v2; ob = b2; od = dn2;
        end
    end

    function automatic int cfg_nf();  return (sel == 1) ? 1 : 2;    endfunction
    function automatic int cfg_db();  return (sel == 1) ? 4 : 1;    endfunction
    function automatic int cfg_bx();  return (sel == 2) ? 1020 : 151; endfunction

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Expected glyph list from the numeric value of each field.
    task automatic build_expect(input longint data, input bit lz_in);
        longint radix, fv, p, hi;
        int nf, nd, db;
        nf = cfg_nf(); nd = 4; db = cfg_db();
        radix = longint'(1) << db;
        ex.delete(); ey.delete(); en.delete();
        for (int f = 0; f < nf; f++) begin
            fv = (data >> (f * nd * db)) % (longint'(1) << (nd * db));
            for (int d = 0; d < nd; d++) begin
                p = 1;
                for (int k = 0; k < nd - 1 - d; k++) p = p * radix;
                hi = fv / p;
                ex.push_back((cfg_bx() + d * 9) % 1024);
                ey.push_back((87 + f * 16) % 1024);
                if (lz_in && hi == 0 && d != nd - 1) en.push_back(12);
                else en.push_back(int'(hi % radix));
            end
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_valid"}, ov, 0);
        chk({tag, "_busy"}, ob, 0);
        chk({tag, "_done"}, od, 0);
        chk({tag, "_number"}, on, 12);
    endtask

    task automatic run_pass(input longint data, input bit lz_in, input int stall_digit,
                            input int stall_len, input bit rand_ready, input bit disturb);
        int cyc, idx, stalls, stalled, extra;
        bit got_done;
        build_expect(data, lz_in);
        data_s = data; lz = lz_in; ready = 1'b1;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        cyc = 0; idx = 0; stalls = 0; stalled = 0; got_done = 1'b0;
        while (!got_done && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (disturb && cyc == 3) begin
                data_s = ~data;
                start  = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (cyc == 1) chk("busy_after_load", ob, 1);
            if (ov) begin
                if (idx < ex.size()) begin
                    chk($sformatf("x[%0d]", idx), ox, ex[idx]);
                    chk($sformatf("y[%0d]", idx), oy, ey[idx]);
                    chk($sformatf("number[%0d]", idx), on, en[idx]);
                end else begin
                    chk("digit_overrun", idx, ex.size() - 1);
                end
                if (idx == stall_digit && stalled < stall_len) begin
                    ready = 1'b0;
                    stalled++;
                end else if (rand_ready) begin
                    ready = ($urandom_range(0, 2) != 0);
                end else begin
                    ready = 1'b1;
                end
                if (ready) idx++;
                else stalls++;
            end else begin
                ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            if (od) got_done = 1'b1;
        end
        chk("done_seen", got_done, 1);
        chk("digits_accepted", idx, ex.size());
        chk("done_latency", cyc, 2 + 2 * ex.size() + stalls);
        chk("busy_at_done", ob, 0);
        chk("valid_at_done", ov, 0);
        chk("number_at_done", on, 12);
        start = 1'b0; ready = 1'b1; extra = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (od || ov || ob) extra++;
        end
        chk("quiet_after_done", extra, 0);
    endtask

    initial begin
        int guard, dn_seen;
        rst_n = 1'b0; start = 1'b0; lz = 1'b0; ready = 1'b1; data_s = '0; sel = 0;
        repeat (2) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            chk_idle("reset");
            chk("reset_x", ox, cfg_bx());
            chk("reset_y", oy, 87);
        end
        @(negedge clk) rst_n = 1'b1;

        sel = 0;
        run_pass(64'h96, 1'b0, -1, 0, 1'b0, 1'b0);
        run_pass(64'h69, 1'b0, -1, 0, 1'b0, 1'b0);
        run_pass(64'h96, 1'b0, 1, 5, 1'b0, 1'b0);
        run_pass(64'h5A, 1'b1, -1, 0, 1'b0, 1'b0);
        run_pass(64'h3C, 1'b0, -1, 0, 1'b0, 1'b1);

        sel = 1;
        run_pass(64'h00A3, 1'b1, -1, 0, 1'b0, 1'b0);
        run_pass(64'h0000, 1'b1, -1, 0, 1'b0, 1'b0);
        run_pass(64'h00A3, 1'b0, -1, 0, 1'b0, 1'b0);
        run_pass(64'hF00D, 1'b1, 2, 3, 1'b0, 1'b1);

        sel = 2;
        run_pass(64'h96, 1'b0, -1, 0, 1'b0, 1'b0);

        // Abort a pass with reset while the third digit waits for READY.
        sel = 0;
        data_s = 64'hC3; lz = 1'b0; ready = 1'b1;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        guard = 0;
        while (!(ov && x0 == 10'd169) && guard < 100) begin
            @(negedge clk);
            guard++;
            if (ov && x0 == 10'd169) ready = 1'b0;
        end
        chk("reached_third_digit", guard < 100, 1);
        ready = 1'b0;
        #5 rst_n = 1'b0;
        #1;
        chk_idle("async_reset");
        chk("async_reset_x", ox, 151);
        chk("async_reset_y", oy, 87);
        dn_seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (od) dn_seen++;
        end
        rst_n = 1'b1; ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (od || ov) dn_seen++;
        end
        chk("no_done_after_abort", dn_seen, 0);
        run_pass(64'hC3, 1'b0, -1, 0, 1'b0, 1'b0);

        for (int i = 0; i < 9; i++) begin
            sel = i % 3;
            run_pass(longint'($urandom), 1'($urandom_range(0, 1)), -1, 0, 1'b1, 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
